// File: rtl/aes_pkg.sv
// Shared AES definitions: round constants, FSM states, block layout and the
// GF(2^8) inverse-round primitives used by the decryption datapath.
package aes_pkg;

  localparam int NR    = 10;
  localparam int RK_AW = 4;

  typedef logic [7:0]   byte_t;
  // Byte k of a block lives at [127-8k -: 8]; bytes fill columns first (row = k%4).
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t acc = '0;
    byte_t p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic byte_t gf_inv(input byte_t a);
    byte_t sq  = a;
    byte_t acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic byte_t inv_sbox(input byte_t b);
    byte_t x;
    x = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(x);
  endfunction

  function automatic block_t inv_shift_rows(input block_t s);
    block_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic block_t inv_sub_bytes(input block_t s);
    block_t o;
    for (int k = 0; k < 16; k++)
      o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic block_t inv_mix_columns(input block_t s);
    block_t o;
    byte_t  a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational single AES inverse round; the last round skips InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] round_key_i,
  input  logic         is_final_i,
  output logic [127:0] state_o
);

  block_t keyed;

  always_comb begin
    keyed   = inv_sub_bytes(inv_shift_rows(state_i)) ^ round_key_i;
    state_o = is_final_i ? keyed : inv_mix_columns(keyed);
  end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 decryption controller: one inverse round per clock over a
// single state register, round keys fetched from an external store by index.
module aes_inv_cipher_ctrl
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_data,
  output logic [RK_AW-1:0]   rk_addr,
  input  logic [127:0]       rk_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic               busy
);

  state_e             fsm_q, fsm_d;
  logic [RK_AW-1:0]   cnt_q, cnt_d;
  block_t             state_q, state_d;
  block_t             out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  block_t             round_out;

  aes_inv_round u_round (
    .state_i     (state_q),
    .round_key_i (rk_data),
    .is_final_i  (fsm_q == FINAL),
    .state_o     (round_out)
  );

  always_comb begin
    // NOTE: every output of this block is assigned a default first so no path leaves a latch.
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rk_addr     = RK_AW'(NR);
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = in_data ^ rk_data;
          cnt_d   = RK_AW'(NR - 1);
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        rk_addr = cnt_q;
        state_d = round_out;
        if (cnt_q == RK_AW'(1)) fsm_d = FINAL;
        else                    cnt_d = cnt_q - 1'b1;
      end
      FINAL: begin
        rk_addr     = '0;
        out_data_d  = round_out;
        out_valid_d = 1'b1;
        fsm_d       = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      cnt_q       <= RK_AW'(NR - 1);
      state_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign busy      = (fsm_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Scoreboard bench for aes_inv_cipher_ctrl: FIPS-197 vectors plus random blocks
// encrypted by a forward-cipher model, with timing and rk_addr trace checks.
module tb_aes_inv_cipher_ctrl;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  aes_inv_cipher_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_addr   (rk_addr),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            accept_cyc = 0;
  logic [127:0]  exp_q [$];
  logic [7:0]    sbox  [0:255];
  logic [127:0]  rk_c1 [0:10];
  logic [127:0]  rk_b  [0:10];
  bit            key_sel = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    rk_data = '0;
    if (rk_addr <= 4'd10) rk_data = key_sel ? rk_b[rk_addr] : rk_c1[rk_addr];
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Output side of the scoreboard: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("out_unexpected", {127'd0, out_valid}, 128'd0);
      else                   check("out_data", out_data, exp_q.pop_front());
    end
  end

  // ---------------- forward-cipher reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
      sbox[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key, input bit sel);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      if (sel) rk_b[r]  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else     rk_c1[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  function automatic logic [127:0] enc_round(input logic [127:0] s, input bit mix);
    logic [127:0] a, b;
    logic [7:0]   x0, x1, x2, x3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        a[127-8*(r+4*c) -: 8] = sbox[s[127-8*(r+4*((c+r)%4)) -: 8]];
    b = a;
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        x0 = a[127-32*c -: 8]; x1 = a[119-32*c -: 8];
        x2 = a[111-32*c -: 8]; x3 = a[103-32*c -: 8];
        b[127-32*c -: 8] = xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3;
        b[119-32*c -: 8] = x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3;
        b[111-32*c -: 8] = x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3;
        b[103-32*c -: 8] = xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3);
      end
    end
    return b;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s = pt ^ rk_c1[0];
    for (int r = 1; r < 10; r++) s = enc_round(s, 1'b1) ^ rk_c1[r];
    return enc_round(s, 1'b0) ^ rk_c1[10];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers (enter and leave 1 time unit after a rising edge) ----------------
  task automatic send_block(input logic [127:0] ct, input logic [127:0] pt);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = ct;
    while (guard < 100) begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
    end
    check("accept_wait", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    exp_q.push_back(pt);
    accept_cyc = cyc;
    #1;
    in_valid = 1'b0;
    in_data  = rand128();
  endtask

  task automatic wait_out(input bit trace);
    int lat = 0;
    int exp_rk;
    if (trace) check("rk_addr_k0", {124'd0, rk_addr}, 128'd9);
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      exp_rk = (lat < 9) ? 9 - lat : ((lat == 9) ? 0 : 10);
      if (trace && lat <= 10) check("rk_addr_trace", {124'd0, rk_addr}, 128'(exp_rk));
      if (out_valid) break;
    end
    check("latency", 128'(lat), 128'd10);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("out_valid_wait", {127'd0, out_valid}, 128'd1);
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] pt, ct;
    int           prev_acc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    build_sbox();
    expand_key(C1_KEY, 1'b0);
    expand_key(B_KEY, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_in_ready",  {127'd0, in_ready},  128'd1);
    check("rst_busy",      {127'd0, busy},      128'd0);
    check("rst_rk_addr",   {124'd0, rk_addr},   128'd10);
    check("rst_out_data",  out_data,            128'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 C.1 with latency and key-index trace
    send_block(C1_CT, C1_PT);
    wait_out(1'b1);

    // FIPS-197 App. B with the alternate key schedule
    @(posedge clk);
    #1;
    key_sel = 1'b1;
    send_block(B_CT, B_PT);
    wait_valid(20);
    @(posedge clk);
    #1;
    key_sel = 1'b0;

    // Backpressure: result must hold while downstream stalls
    out_ready = 1'b0;
    pt = rand128();
    send_block(encrypt(pt), pt);
    wait_valid(20);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", {127'd0, out_valid}, 128'd1);
      check("bp_out_data",  out_data,            pt);
      check("bp_in_ready",  {127'd0, in_ready},  128'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready",  {127'd0, in_ready},  128'd1);
    check("bp_release_busy",      {127'd0, busy},      128'd0);
    check("bp_release_out_valid", {127'd0, out_valid}, 128'd0);

    // Busy rejection: a second block offered mid-round must be ignored
    pt = rand128();
    send_block(encrypt(pt), pt);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = encrypt(rand128());
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("rej_busy",     {127'd0, busy},     128'd1);
    check("rej_in_ready", {127'd0, in_ready}, 128'd0);
    wait_valid(20);
    @(posedge clk);
    #1;
    check("rej_sb_empty", 128'(exp_q.size()), 128'd0);

    // Back-to-back random blocks: one block per NR+2 cycles
    prev_acc = 0;
    for (int i = 0; i < 12; i++) begin
      pt = rand128();
      ct = encrypt(pt);
      send_block(ct, pt);
      if (i > 0) check("period", 128'(accept_cyc - prev_acc), 128'd12);
      prev_acc = accept_cyc;
      wait_out(1'b1);
    end
    @(posedge clk);
    #1;

    // Async reset in the middle of round 5, between clock edges
    send_block(C1_CT, C1_PT);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {127'd0, out_valid}, 128'd0);
    check("arst_in_ready",  {127'd0, in_ready},  128'd1);
    check("arst_busy",      {127'd0, busy},      128'd0);
    check("arst_rk_addr",   {124'd0, rk_addr},   128'd10);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("arst_no_output", {127'd0, out_valid}, 128'd0);
    send_block(C1_CT, C1_PT);
    wait_out(1'b0);
    @(posedge clk);
    #1;

    check("sb_empty", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
